// File: rtl/register_bank_pkg.sv
// Shared defaults and clear-sequencer encodings for the register bank.
package register_bank_pkg;

    localparam int DEF_WORD_SIZE     = 16;
    localparam int DEF_REG_ADDR_SIZE = 3;
    localparam int DEF_REG_NUM       = 8;

    // Clear sequencer states
    typedef enum logic [1:0] {
        CLR_IDLE  = 2'd0,
        CLR_SWEEP = 2'd1,
        CLR_DONE  = 2'd2
    } clr_state_t;

endpackage

// File: rtl/register_bank_if.sv
// Request/response bundle between the core pipeline (master) and the bank (slave).
interface register_bank_if
    import register_bank_pkg::*;
#(
    parameter int WORD_SIZE     = DEF_WORD_SIZE,
    parameter int REG_ADDR_SIZE = DEF_REG_ADDR_SIZE
) ();

    logic                     get_enable;
    logic [REG_ADDR_SIZE-1:0] num1;
    logic [REG_ADDR_SIZE-1:0] num2;
    logic [WORD_SIZE-1:0]     out1;
    logic [WORD_SIZE-1:0]     out2;
    logic                     busy1;
    logic                     busy2;
    logic                     out_valid;
    logic                     set_enable;
    logic [REG_ADDR_SIZE-1:0] set_num;
    logic [WORD_SIZE-1:0]     set_val;
    logic                     reserve_enable;
    logic [REG_ADDR_SIZE-1:0] reserve_num;
    logic                     clear_start;
    logic                     clear_busy;
    logic                     clear_done;

    modport master (
        output get_enable, num1, num2, set_enable, set_num, set_val,
               reserve_enable, reserve_num, clear_start,
        input  out1, out2, busy1, busy2, out_valid, clear_busy, clear_done
    );

    modport slave (
        input  get_enable, num1, num2, set_enable, set_num, set_val,
               reserve_enable, reserve_num, clear_start,
        output out1, out2, busy1, busy2, out_valid, clear_busy, clear_done
    );

endinterface

// File: rtl/register_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on reserve, cleared on
// writeback or sweep, with registered lookups that see the same-cycle updates.
module register_scoreboard
    import register_bank_pkg::*;
#(
    parameter int REG_ADDR_SIZE = DEF_REG_ADDR_SIZE,
    parameter int REG_NUM       = DEF_REG_NUM
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clr_en,
    input  logic [REG_ADDR_SIZE-1:0] clr_num,
    input  logic                     set_en,
    input  logic [REG_ADDR_SIZE-1:0] set_num,
    input  logic                     sweep_en,
    input  logic [REG_ADDR_SIZE-1:0] sweep_idx,
    input  logic                     lookup_en,
    input  logic [REG_ADDR_SIZE-1:0] num1,
    input  logic [REG_ADDR_SIZE-1:0] num2,
    output logic                     busy1,
    output logic                     busy2
);

    logic [REG_NUM-1:0] pending;
    logic [REG_NUM-1:0] pending_next;

    // Next pending vector; a reserve is applied last so a new producer wins
    always_comb begin
        pending_next = pending;
        if (sweep_en) pending_next[sweep_idx] = 1'b0;
        if (clr_en)   pending_next[clr_num]   = 1'b0;
        if (set_en)   pending_next[set_num]   = 1'b1;
    end

    // Pending state and lookup registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending <= '0;
            busy1   <= 1'b0;
            busy2   <= 1'b0;
        end else begin
            pending <= pending_next;
            if (lookup_en) begin
                busy1 <= pending_next[num1];
                busy2 <= pending_next[num2];
            end
        end
    end

endmodule

// File: rtl/register_bank.sv
// General-purpose register bank with write-first bypass, optional hardwired
// zero register, pending-write scoreboard and a multi-cycle clear sweep.
module register_bank
    import register_bank_pkg::*;
#(
    parameter int WORD_SIZE     = DEF_WORD_SIZE,
    parameter int REG_ADDR_SIZE = DEF_REG_ADDR_SIZE,
    parameter int REG_NUM       = DEF_REG_NUM,
    parameter int ZERO_REG      = 0
) (
    input  logic            clock,
    input  logic            reset,
    register_bank_if.slave  bus
);

    localparam logic [REG_ADDR_SIZE-1:0] LAST_IDX = REG_ADDR_SIZE'(REG_NUM - 1);

    logic [WORD_SIZE-1:0]     regs [REG_NUM];
    clr_state_t               clr_state;
    logic [REG_ADDR_SIZE-1:0] idx;
    logic                     idle;
    logic                     sweeping;
    logic                     get_ok;
    logic                     set_ok;
    logic                     reserve_ok;

    // Requests are only honoured while the sequencer is idle; register 0
    // swallows writes and reserves when it is hardwired to zero.
    assign idle       = (clr_state == CLR_IDLE);
    assign sweeping   = (clr_state == CLR_SWEEP);
    assign get_ok     = idle && bus.get_enable;
    assign set_ok     = idle && bus.set_enable &&
                        !(ZERO_REG != 0 && bus.set_num == '0);
    assign reserve_ok = idle && bus.reserve_enable &&
                        !(ZERO_REG != 0 && bus.reserve_num == '0);

    function automatic logic [WORD_SIZE-1:0] read_port(input logic [REG_ADDR_SIZE-1:0] num);
        if (ZERO_REG != 0 && num == '0)
            return '0;
        if (set_ok && bus.set_num == num)
            return bus.set_val;
        return regs[num];
    endfunction

    // Data array: sweep zeroing takes priority, otherwise writeback
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
        end else if (sweeping) begin
            regs[idx] <= '0;
        end else if (set_ok) begin
            regs[bus.set_num] <= bus.set_val;
        end
    end

    // Read data registers with write-first bypass
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.out1      <= '0;
            bus.out2      <= '0;
            bus.out_valid <= 1'b0;
        end else begin
            bus.out_valid <= get_ok;
            if (get_ok) begin
                bus.out1 <= read_port(bus.num1);
                bus.out2 <= read_port(bus.num2);
            end
        end
    end

    // Clear sequencer: IDLE -> SWEEP (one register per cycle) -> DONE -> IDLE
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clr_state      <= CLR_IDLE;
            idx            <= '0;
            bus.clear_busy <= 1'b0;
            bus.clear_done <= 1'b0;
        end else begin
            case (clr_state)
                CLR_IDLE: begin
                    bus.clear_done <= 1'b0;
                    if (bus.clear_start) begin
                        clr_state      <= CLR_SWEEP;
                        idx            <= '0;
                        bus.clear_busy <= 1'b1;
                    end
                end
                CLR_SWEEP: begin
                    if (idx == LAST_IDX) begin
                        clr_state      <= CLR_DONE;
                        bus.clear_busy <= 1'b0;
                        bus.clear_done <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                CLR_DONE: begin
                    clr_state      <= CLR_IDLE;
                    bus.clear_done <= 1'b0;
                end
                default: begin
                    clr_state      <= CLR_IDLE;
                    bus.clear_busy <= 1'b0;
                    bus.clear_done <= 1'b0;
                end
            endcase
        end
    end

    register_scoreboard #(
        .REG_ADDR_SIZE (REG_ADDR_SIZE),
        .REG_NUM       (REG_NUM)
    ) u_scoreboard (
        .clock     (clock),
        .reset     (reset),
        .clr_en    (set_ok),
        .clr_num   (bus.set_num),
        .set_en    (reserve_ok),
        .set_num   (bus.reserve_num),
        .sweep_en  (sweeping),
        .sweep_idx (idx),
        .lookup_en (get_ok),
        .num1      (bus.num1),
        .num2      (bus.num2),
        .busy1     (bus.busy1),
        .busy2     (bus.busy2)
    );

endmodule
